// File: rtl/rib_ex_bridge_2023211063.sv
// rib_ex_bridge_2023211063
// Bridges the core's level-held data-side RIB request onto a valid/ready
// request channel with a separate response strobe toward a variable-latency slave.
// It returns a one-cycle ack with read data to the core, and holds the core
// while a transaction is outstanding. At most one transaction is in flight.
// Optional feature: define RIB_BRIDGE_TIMEOUT_EN to force an error completion
// (rdata 32'hDEADBEEF, err_o=1) after TIMEOUT cycles spent in REQ/WAIT.
module rib_ex_bridge_2023211063 #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  output logic              core_ack_o,
  output logic [DATA_W-1:0] core_rdata_o,
  output logic              core_hold_o,
  output logic              s_valid_o,
  input  logic              s_ready_i,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_wdata_o,
  input  logic              s_rvalid_i,
  input  logic [DATA_W-1:0] s_rdata_i,
  output logic              err_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // A timeout below 2 cycles leaves no room for a slave response
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("TIMEOUT must be at least 2");
  end

  // Request fields captured in IDLE and replayed to the slave
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  logic [1:0]        state_q, state_d;
  req_t              req_q, req_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

`ifdef RIB_BRIDGE_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // Next-state and datapath update for the bridge FSM
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rdata_d = rdata_q;
`ifdef RIB_BRIDGE_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        rdata_d = '0;
        if (core_req_i) begin
          req_d.we    = core_we_i;
          req_d.addr  = core_addr_i;
          req_d.wdata = core_wdata_i;
          state_d     = ST_REQ;
`ifdef RIB_BRIDGE_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      ST_REQ: begin
        // A response is only meaningful once the request has been accepted
        if (s_ready_i) begin
          if (s_rvalid_i) begin
            rdata_d = req_q.we ? '0 : s_rdata_i;
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (s_rvalid_i) begin
          rdata_d = req_q.we ? '0 : s_rdata_i;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        rdata_d = '0;
        state_d = ST_IDLE;
      end
      default: begin
        rdata_d = '0;
        state_d = ST_IDLE;
      end
    endcase
`ifdef RIB_BRIDGE_TIMEOUT_EN
    // Real completion wins over a timeout landing in the same cycle
    if (state_q == ST_REQ || state_q == ST_WAIT) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (state_d != ST_RESP && cnt_q == CNT_W'(TIMEOUT - 1)) begin
        state_d = ST_RESP;
        rdata_d = DATA_W'(32'hDEADBEEF);
        err_d   = 1'b1;
      end
    end
`endif
  end

  // State, request latches and response data registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      rdata_q <= '0;
`ifdef RIB_BRIDGE_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
`ifdef RIB_BRIDGE_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign core_ack_o   = (state_q == ST_RESP);
  assign core_rdata_o = rdata_q;
  assign s_valid_o    = (state_q == ST_REQ);
  assign s_we_o       = req_q.we;
  assign s_addr_o     = req_q.addr;
  assign s_wdata_o    = req_q.wdata;

  // Hold is gated by reset so it drops immediately even with the request still high
  assign core_hold_o  = rst & (((state_q == ST_IDLE) & core_req_i) |
                               (state_q == ST_REQ) | (state_q == ST_WAIT));

`ifdef RIB_BRIDGE_TIMEOUT_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: doc/rib_ex_bridge_2023211063.md
Name: rib_ex_bridge_2023211063

Overview:
- Sits directly downstream of the core's data-side RIB port (rib_ex_addr/data/req/we/ack).
- Converts the core's level-held request into a valid/ready request plus a response handshake toward a variable-latency slave.
- Returns a one-cycle ack with read data to the core.
- Drives a hold flag into the core's bus-hold input while a transaction is outstanding.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, cycles in REQ+WAIT before forced error completion; used only with the optional feature

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- core_req_i  in  1  core access request, held until ack
- core_we_i  in  1  1 = write, 0 = read
- core_addr_i  in  ADDR_W  access address
- core_wdata_i  in  DATA_W  write data
- core_ack_o  out  1  one-cycle completion pulse
- core_rdata_o  out  DATA_W  read data, valid while core_ack_o=1
- core_hold_o  out  1  stall request to core while transaction outstanding
- s_valid_o  out  1  request valid to slave
- s_ready_i  in  1  slave accepts request
- s_we_o  out  1  latched write enable
- s_addr_o  out  ADDR_W  latched address
- s_wdata_o  out  DATA_W  latched write data
- s_rvalid_i  in  1  slave response valid (reads and writes)
- s_rdata_i  in  DATA_W  slave read data
- err_o  out  1  timeout pulse, coincident with core_ack_o

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-low.
- Reset values: state=IDLE; all outputs 0; latches 0; timeout counter 0.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE, core_req_i=1: latch core_we_i, core_addr_i, core_wdata_i; go to REQ.
- IDLE, core_req_i=0: remain in IDLE.
- REQ:
  - s_valid_o=1; s_we_o, s_addr_o and s_wdata_o held stable from the latches.
  - s_ready_i=1 and s_rvalid_i=0: go to WAIT.
  - s_ready_i=1 and s_rvalid_i=1 in the same cycle: accept the response; go to RESP.
  - s_ready_i=0: stay in REQ; s_rvalid_i is ignored.
- WAIT:
  - s_valid_o=0.
  - On s_rvalid_i=1: register s_rdata_i into core_rdata_o if read (write: core_rdata_o=0); go to RESP.
- RESP:
  - core_ack_o=1 for exactly one cycle; core_rdata_o held.
  - Next state IDLE; core_rdata_o returns to 0 the following cycle.
- core_hold_o is combinational: (state==IDLE & core_req_i) | state==REQ | state==WAIT. It is 0 in RESP.
- Minimum latency: request seen in IDLE at cycle 0; slave ready+rvalid at cycle 1; ack at cycle 2.
- Back-to-back: core_req_i still high in the IDLE cycle after RESP is treated as a new request. The core must have advanced by then.
- core_req_i dropped mid-transaction: the slave transaction still completes and the ack pulse is still issued; the core ignores it.
- Latched fields never change outside IDLE.
- Reset asserted mid-transaction: immediate return to IDLE; s_valid_o and core_hold_o drop asynchronously; no ack.
- Outstanding transactions: at most 1.
- s_rvalid_i in IDLE or RESP: ignored.

Optional Feature:
- Macro: RIB_BRIDGE_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When the counter reaches TIMEOUT-1 without completion: go to RESP with core_rdata_o=32'hDEADBEEF and err_o=1 for that RESP cycle.
  - s_valid_o drops.
  - A late s_rvalid_i is ignored.
- Undefined: no counter; the bridge waits indefinitely; err_o is tied 0.

Test Plan:
- Read, zero-wait slave: core_req_i=1, we=0, addr=0x1000_0004; s_ready_i=1 and s_rvalid_i=1 with s_rdata_i=0x12345678 in the REQ cycle -> core_ack_o=1 with core_rdata_o=0x12345678 two cycles after the request; core_hold_o high for cycles 0-1.
- Write, stalled slave: we=1, wdata=0xA5A5A5A5; s_ready_i low 3 cycles, then rvalid 2 cycles after accept -> s_valid_o high 4 cycles; s_wdata_o stable at 0xA5A5A5A5; one ack; core_rdata_o=0.
- Back-to-back: two reads with req held continuously; slave returns 0x11 then 0x22 -> two separate ack pulses separated by an IDLE cycle; data in order.
- Reset mid-WAIT: rst low for one cycle while in WAIT -> s_valid_o, core_hold_o and core_ack_o are 0 immediately; the late s_rvalid_i produces no ack.
- Timeout (macro on, TIMEOUT=8): slave never raises s_rvalid_i -> err_o=1, core_ack_o=1, core_rdata_o=0xDEADBEEF after 8 cycles in REQ/WAIT. With the macro off, the bridge is still in WAIT after 1000 cycles.
